// File: rtl/if_id_fifo.sv
// IF/ID decoupling FIFO: buffers fetched {instr, pc, pc_add4} triples
// in order, with flush for redirects and backpressure to fetch.
module if_id_fifo #(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_instr,
    input  logic [31:0]                in_pc,
    input  logic [31:0]                in_pc_add4,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_instr,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_pc_add4,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_add4;
    } if_id_t;

    if_id_t          r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    if_id_t          w_head;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = in_valid & ~w_full;
    assign w_pop   = out_ready & ~w_empty;
    assign w_head  = r_mem[r_rd_ptr];

    assign in_ready  = ~w_full;
    assign out_valid = ~w_empty;
    assign count     = r_count;

    // Empty buffer presents a NOP so decode never sees stale data.
    assign out_instr   = w_empty ? 32'h0000_0013 : w_head.instr;
    assign out_pc      = w_empty ? 32'h0 : w_head.pc;
    assign out_pc_add4 = w_empty ? 32'h0 : w_head.pc_add4;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            // Wrong-path push this cycle is dropped with everything else.
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= '{instr: in_instr, pc: in_pc,
                                     pc_add4: in_pc_add4};
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_if_id_fifo.sv
// Scoreboard bench for if_id_fifo: accepted pushes feed a queue,
// an output monitor pops and compares every consumed entry.
module tb_if_id_fifo;

    localparam int DEPTH = 2;
    localparam int CW = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_instr;
    logic [31:0]   in_pc;
    logic [31:0]   in_pc_add4;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_instr;
    logic [31:0]   out_pc;
    logic [31:0]   out_pc_add4;
    logic [CW-1:0] count;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } ent_t;

    ent_t sb[$];
    int   checks = 0;
    int   failures = 0;

    if_id_fifo #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .in_pc_add4  (in_pc_add4),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .out_pc_add4 (out_pc_add4),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h @%0t", name, act, exp,
                     $time);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] instr,
                         input logic [31:0] pc);
        in_valid   = v;
        in_instr   = instr;
        in_pc      = pc;
        in_pc_add4 = pc + 32'd4;
    endtask

    task automatic next;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_count"}, 32'(count), 32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_out_instr"}, out_instr, 32'h0000_0013);
        chk({tag, "_out_pc"}, out_pc, 32'h0);
        chk({tag, "_out_pc_add4"}, out_pc_add4, 32'h0);
    endtask

    // Input side: record every accepted, non-discarded push.
    always @(negedge clk) begin
        if (rst === 1'b0 && flush === 1'b0 && in_valid === 1'b1 &&
            in_ready === 1'b1) begin
            sb.push_back('{instr: in_instr, pc: in_pc,
                           pc4: in_pc + 32'd4});
        end
    end

    // Output side: compare each consumed head, then honour flush/reset.
    always @(negedge clk) begin
        ent_t e;
        if (out_valid === 1'b1 && out_ready === 1'b1 && rst === 1'b0) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pop: pc %h with empty scoreboard",
                         out_pc);
            end else begin
                e = sb.pop_front();
                chk("pop_instr", out_instr, e.instr);
                chk("pop_pc", out_pc, e.pc);
                chk("pop_pc_add4", out_pc_add4, e.pc4);
            end
        end
        if (rst === 1'b1 || flush === 1'b1) sb.delete();
    end

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b1, 32'hDEAD_0001, 32'h100);
        next();
        next();
        rst = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk_reset_state("reset");

        // Streaming, out_ready held high
        next();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'hA000_0000 + 32'(i), 32'(4 * i));
            @(negedge clk);
            chk("stream_count_le1", 32'(count <= CW'(1)), 32'd1);
            if (i > 0) begin
                chk("stream_latency_valid", 32'(out_valid), 32'd1);
                chk("stream_latency_pc", out_pc, 32'(4 * (i - 1)));
            end
            next();
        end
        drive(1'b0, 32'h0, 32'h0);
        next();
        @(negedge clk);
        chk("stream_drained", 32'(count), 32'd0);

        // Fill and backpressure
        next();
        out_ready = 1'b0;
        drive(1'b1, 32'hE000_0000, 32'h50);
        next();
        drive(1'b1, 32'hE000_0001, 32'h54);
        next();
        drive(1'b1, 32'hE000_0002, 32'h58);
        @(negedge clk);
        chk("full_count", 32'(count), 32'd2);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        next();
        out_ready = 1'b1;
        @(negedge clk);
        chk("full_pop_in_ready", 32'(in_ready), 32'd0);
        chk("full_head_pc", out_pc, 32'h50);
        next();
        out_ready = 1'b0;
        @(negedge clk);
        chk("after_pop_in_ready", 32'(in_ready), 32'd1);
        chk("after_pop_count", 32'(count), 32'd1);
        next();
        drive(1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("refill_count", 32'(count), 32'd2);
        next();
        out_ready = 1'b1;
        next();
        next();
        @(negedge clk);
        chk("fill_drained", 32'(count), 32'd0);

        // Simultaneous push and pop at count=1
        next();
        out_ready = 1'b0;
        drive(1'b1, 32'hB000_0000, 32'h200);
        next();
        out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, 32'hB000_0000 + 32'(i), 32'h200 + 32'(4 * i));
            @(negedge clk);
            chk("pushpop_count", 32'(count), 32'd1);
            next();
        end
        drive(1'b0, 32'h0, 32'h0);
        next();
        @(negedge clk);
        chk("pushpop_drained", 32'(count), 32'd0);

        // Flush at count=2 with a wrong-path push and a pop
        next();
        out_ready = 1'b0;
        drive(1'b1, 32'hC000_0000, 32'h80);
        next();
        drive(1'b1, 32'hC000_0001, 32'h84);
        next();
        flush     = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 32'hBAD0_0020, 32'h20);
        next();
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b1, 32'hC000_0040, 32'h40);
        @(negedge clk);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_out_instr", out_instr, 32'h0000_0013);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        next();
        drive(1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("flush_newpath_valid", 32'(out_valid), 32'd1);
        chk("flush_newpath_pc", out_pc, 32'h40);
        next();
        out_ready = 1'b1;
        next();

        // Reset with flush and push at count=2
        out_ready = 1'b0;
        drive(1'b1, 32'hD000_0000, 32'h90);
        next();
        drive(1'b1, 32'hD000_0001, 32'h94);
        next();
        rst   = 1'b1;
        flush = 1'b1;
        drive(1'b1, 32'hBAD0_0030, 32'h30);
        next();
        rst   = 1'b0;
        flush = 1'b0;
        drive(1'b1, 32'hD000_0060, 32'h60);
        @(negedge clk);
        chk_reset_state("midrst");
        next();
        drive(1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("midrst_push_valid", 32'(out_valid), 32'd1);
        chk("midrst_push_pc", out_pc, 32'h60);
        next();
        out_ready = 1'b1;
        next();
        @(negedge clk);
        chk("final_count", 32'(count), 32'd0);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
